// File: rtl/snes_csync_gen.sv
// -----------------------------------------------------------------------------
// snes_csync_gen
//   SNES PPU-style composite sync generator. Counts master clocks into dots,
//   lines and fields and drives an active-low CSYNC. It reproduces the PPU
//   short-line quirk: line SHORT_LINE of odd non-interlaced fields is 1360
//   mclk instead of 1364. In interlace mode, field 0 carries one extra line,
//   and that last line ends at H_TOTAL/2 (a half line).
//
//   Optional feature macro: CSYNC_SERRATION_EN
//     defined   : vsync lines carry two serrated broad pulses per line
//     undefined : vsync lines carry one broad pulse per line
//
// Ports
//   MCLK_i       in   1  master clock (21.477 MHz)
//   RST_N_i      in   1  synchronous active-low reset
//   EN_i         in   1  count enable; low freezes every register
//   INTERLACE_i  in   1  interlace request, sampled only at a field wrap
//   CSYNC_o      out  1  composite sync, active low
//   DOT_EN_o     out  1  one-mclk dot strobe (h_cnt[1:0]==0)
//   LINE_o       out  9  current line index
//   FIELD_o      out  1  field parity
//   SHORT_o      out  1  high for the whole duration of a short line
//
// Every output is registered, so it shows the counter state of the
// previous cycle.
// -----------------------------------------------------------------------------
module snes_csync_gen #(
   parameter int H_TOTAL    = 1364,
   parameter int H_SHORT    = 1360,
   parameter int HSYNC_LEN  = 100,
   parameter int V_TOTAL    = 262,
   parameter int VSYNC_LINE = 240,
   parameter int VSYNC_CNT  = 3,
   parameter int SHORT_LINE = 240
) (
   input  logic       MCLK_i,
   input  logic       RST_N_i,
   input  logic       EN_i,
   input  logic       INTERLACE_i,
   output logic       CSYNC_o,
   output logic       DOT_EN_o,
   output logic [8:0] LINE_o,
   output logic       FIELD_o,
   output logic       SHORT_o
);

   localparam logic [10:0] H_TOTAL_W = 11'(H_TOTAL);
   localparam logic [10:0] H_SHORT_W = 11'(H_SHORT);
   localparam logic [10:0] HSYNC_W   = 11'(HSYNC_LEN);
   localparam logic [10:0] H_HALF_W  = 11'(H_TOTAL / 2);
   localparam logic [8:0]  V_TOTAL_W = 9'(V_TOTAL);
   localparam logic [8:0]  VS_LO_W   = 9'(VSYNC_LINE);
   localparam logic [8:0]  VS_HI_W   = 9'(VSYNC_LINE + VSYNC_CNT);
   localparam logic [8:0]  SHORT_W   = 9'(SHORT_LINE);
`ifdef CSYNC_SERRATION_EN
   localparam logic [10:0] BROAD_A_W = 11'(H_TOTAL / 2 - HSYNC_LEN);
   localparam logic [10:0] BROAD_B_W = 11'(H_TOTAL - HSYNC_LEN);
`endif

   // counter state
   logic [10:0] h_cnt_q, h_cnt_d;
   logic [8:0]  line_q,  line_d;
   logic        field_q, field_d;
   logic        ilace_q, ilace_d;
   // short-line flag, decided when the line starts and held for the line
   logic        short_q, short_d;

   // output registers
   logic        csync_q, csync_d;
   logic        dot_en_q, dot_en_d;
   logic [8:0]  line_o_q, line_o_d;
   logic        field_o_q, field_o_d;
   logic        short_o_q, short_o_d;

   logic [10:0] h_end;
   logic [10:0] h_last;
   logic [8:0]  v_last;
   logic        half_line;
   logic        vsync_line;

   always_comb begin
      h_cnt_d = h_cnt_q;
      line_d  = line_q;
      field_d = field_q;
      ilace_d = ilace_q;
      short_d = short_q;

      h_end = short_q ? H_SHORT_W : H_TOTAL_W;

      // interlaced field 0 is one line longer, and that last line is a half line
      v_last    = (ilace_q && !field_q) ? V_TOTAL_W : V_TOTAL_W - 9'd1;
      half_line = ilace_q && !field_q && (line_q == v_last);
      h_last    = half_line ? H_HALF_W - 11'd1 : h_end - 11'd1;

      if (h_cnt_q == h_last) begin
         h_cnt_d = 11'd0;
         if (line_q == v_last) begin
            line_d  = 9'd0;
            field_d = !field_q;
            ilace_d = INTERLACE_i;
         end else begin
            line_d = line_q + 9'd1;
         end
         // decide the next line's length now so it stays fixed for the whole line
         short_d = (line_d == SHORT_W) && field_d && !ilace_d;
      end else begin
         h_cnt_d = h_cnt_q + 11'd1;
      end

      vsync_line = (line_q >= VS_LO_W) && (line_q < VS_HI_W);

      if (!vsync_line) begin
         csync_d = !(h_cnt_q < HSYNC_W);
      end else begin
`ifdef CSYNC_SERRATION_EN
         csync_d = !((h_cnt_q < BROAD_A_W) ||
                     ((h_cnt_q >= H_HALF_W) && (h_cnt_q < BROAD_B_W)));
`else
         csync_d = !(h_cnt_q < (h_end - HSYNC_W));
`endif
      end

      dot_en_d  = (h_cnt_q[1:0] == 2'd0);
      line_o_d  = line_q;
      field_o_d = field_q;
      short_o_d = short_q;
   end

   always_ff @(posedge MCLK_i) begin
      if (!RST_N_i) begin
         h_cnt_q   <= 11'd0;
         line_q    <= 9'd0;
         field_q   <= 1'b0;
         ilace_q   <= 1'b0;
         short_q   <= 1'b0;
         csync_q   <= 1'b1;
         dot_en_q  <= 1'b0;
         line_o_q  <= 9'd0;
         field_o_q <= 1'b0;
         short_o_q <= 1'b0;
      end else if (EN_i) begin
         h_cnt_q   <= h_cnt_d;
         line_q    <= line_d;
         field_q   <= field_d;
         ilace_q   <= ilace_d;
         short_q   <= short_d;
         csync_q   <= csync_d;
         dot_en_q  <= dot_en_d;
         line_o_q  <= line_o_d;
         field_o_q <= field_o_d;
         short_o_q <= short_o_d;
      end
   end

   assign CSYNC_o  = csync_q;
   assign DOT_EN_o = dot_en_q;
   assign LINE_o   = line_o_q;
   assign FIELD_o  = field_o_q;
   assign SHORT_o  = short_o_q;

endmodule

// File: tb/tb_snes_csync_gen.sv
// -----------------------------------------------------------------------------
// tb_snes_csync_gen
//   Drives two generators from the same inputs: a scaled-down one (short
//   lines and fields, so field-level behaviour is reachable quickly) and one
//   with the default timing. Each cycle both are compared with a line/field
//   level reference model. Directed steps are followed by a randomized phase.
// -----------------------------------------------------------------------------
module tb_snes_csync_gen;

   typedef struct {
      int ht, hs, hl, vt, vl, vc, sl;
   } mparam_t;

   typedef struct {
      int h, line, field, ilace;
      int csync, dot, line_o, field_o, short_o;
   } mstate_t;

   localparam mparam_t PA = '{ht: 40, hs: 36, hl: 6, vt: 12, vl: 8, vc: 3, sl: 8};
   localparam mparam_t PB = '{ht: 1364, hs: 1360, hl: 100, vt: 262, vl: 240, vc: 3, sl: 240};

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic en = 1'b1;
   logic intl = 1'b0;

   logic       a_csync, a_dot, a_field, a_short;
   logic [8:0] a_line;
   logic       b_csync, b_dot, b_field, b_short;
   logic [8:0] b_line;

   int errors = 0;
   int checks = 0;

   mstate_t ma, mb;

   // measurement of the default-timing instance and of short-line duration
   int cyc_n = 0;
   bit meas = 0;
   int prev_b_csync = 1;
   int last_fall = -1;
   int b_period = -1;
   int b_low = -1;
   int prev_a_short = 0;
   int short_run = 0;
   int short_len = -1;

   always #5 clk = ~clk;

   snes_csync_gen #(
      .H_TOTAL(40), .H_SHORT(36), .HSYNC_LEN(6), .V_TOTAL(12),
      .VSYNC_LINE(8), .VSYNC_CNT(3), .SHORT_LINE(8)
   ) dut_a (
      .MCLK_i(clk), .RST_N_i(rst_n), .EN_i(en), .INTERLACE_i(intl),
      .CSYNC_o(a_csync), .DOT_EN_o(a_dot), .LINE_o(a_line),
      .FIELD_o(a_field), .SHORT_o(a_short)
   );

   snes_csync_gen dut_b (
      .MCLK_i(clk), .RST_N_i(rst_n), .EN_i(en), .INTERLACE_i(intl),
      .CSYNC_o(b_csync), .DOT_EN_o(b_dot), .LINE_o(b_line),
      .FIELD_o(b_field), .SHORT_o(b_short)
   );

   // ---------------- reference model ----------------
   function automatic mstate_t m_reset();
      mstate_t s;
      s = '{h: 0, line: 0, field: 0, ilace: 0,
            csync: 1, dot: 0, line_o: 0, field_o: 0, short_o: 0};
      return s;
   endfunction

   function automatic int is_short(mparam_t p, mstate_t s);
      return (s.line == p.sl && s.field == 1 && s.ilace == 0) ? 1 : 0;
   endfunction

   // nominal line length (half-line override is applied separately)
   function automatic int nominal_len(mparam_t p, mstate_t s);
      return is_short(p, s) ? p.hs : p.ht;
   endfunction

   function automatic int line_len(mparam_t p, mstate_t s);
      if (s.ilace == 1 && s.field == 0 && s.line == p.vt) return p.ht / 2;
      return nominal_len(p, s);
   endfunction

   function automatic int field_lines(mparam_t p, mstate_t s);
      return (s.ilace == 1 && s.field == 0) ? p.vt + 1 : p.vt;
   endfunction

   function automatic int csync_of(mparam_t p, mstate_t s);
      bit low;
      if (s.line >= p.vl && s.line < p.vl + p.vc) begin
`ifdef CSYNC_SERRATION_EN
         low = (s.h < p.ht / 2 - p.hl) || (s.h >= p.ht / 2 && s.h < p.ht - p.hl);
`else
         low = s.h < nominal_len(p, s) - p.hl;
`endif
      end else begin
         low = s.h < p.hl;
      end
      return low ? 0 : 1;
   endfunction

   function automatic mstate_t m_step(mparam_t p, mstate_t s, bit r_n, bit e, bit il);
      mstate_t n;
      if (!r_n) return m_reset();
      if (!e) return s;
      n = s;
      n.csync   = csync_of(p, s);
      n.dot     = (s.h % 4 == 0) ? 1 : 0;
      n.line_o  = s.line;
      n.field_o = s.field;
      n.short_o = is_short(p, s);
      n.h = s.h + 1;
      if (n.h >= line_len(p, s)) begin
         n.h = 0;
         n.line = s.line + 1;
         if (n.line >= field_lines(p, s)) begin
            n.line  = 0;
            n.field = 1 - s.field;
            n.ilace = il ? 1 : 0;
         end
      end
      return n;
   endfunction

   // ---------------- checking ----------------
   task automatic chk(input string tag, input logic [31:0] obs, input int exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      ma = m_step(PA, ma, rst_n, en, intl);
      mb = m_step(PB, mb, rst_n, en, intl);
      #1;
      cyc_n++;
      chk("a_csync", 32'(a_csync), ma.csync);
      chk("a_dot",   32'(a_dot),   ma.dot);
      chk("a_line",  32'(a_line),  ma.line_o);
      chk("a_field", 32'(a_field), ma.field_o);
      chk("a_short", 32'(a_short), ma.short_o);
      chk("b_csync", 32'(b_csync), mb.csync);
      chk("b_dot",   32'(b_dot),   mb.dot);
      chk("b_line",  32'(b_line),  mb.line_o);
      chk("b_field", 32'(b_field), mb.field_o);
      chk("b_short", 32'(b_short), mb.short_o);
      if (meas) begin
         if (prev_b_csync == 1 && b_csync === 1'b0) begin
            if (last_fall >= 0) b_period = cyc_n - last_fall;
            last_fall = cyc_n;
         end
         if (prev_b_csync == 0 && b_csync === 1'b1 && last_fall >= 0)
            b_low = cyc_n - last_fall;
         if (a_short === 1'b1) short_run++;
         else if (prev_a_short == 1) short_len = short_run;
         if (a_short !== 1'b1) short_run = 0;
      end
      prev_b_csync = (b_csync === 1'b1) ? 1 : 0;
      prev_a_short = (a_short === 1'b1) ? 1 : 0;
   endtask

   initial begin
      int line_before;
      bit found;

      ma = m_reset();
      mb = m_reset();

      // step 1: reset with EN high and interlace off
      rst_n = 1'b0; en = 1'b1; intl = 1'b0;
      repeat (3) cyc();
      rst_n = 1'b1;
      chk("rst_csync", 32'(a_csync), 1);
      chk("rst_dot",   32'(a_dot),   0);
      chk("rst_line",  32'(a_line),  0);
      chk("rst_field", 32'(a_field), 0);
      chk("rst_short", 32'(a_short), 0);

      // step 2: free run; measure default line period, hsync width, short line
      meas = 1;
      repeat (3000) cyc();
      meas = 0;
      chk("b_line_period", 32'(b_period), 1364);
      chk("b_hsync_width", 32'(b_low), 100);
      chk("a_short_len", 32'(short_len), 36);

      // step 3: request interlace mid-field; model enforces field-boundary switch
      intl = 1'b1;
      repeat (2000) cyc();
      intl = 1'b0;
      repeat (1200) cyc();

      // step 4: reset pulse mid-line (scaled instance at line 3, h 20)
      found = 0;
      for (int i = 0; i < 2000 && !found; i++) begin
         if (ma.line == 3 && ma.h == 20) found = 1;
         else cyc();
      end
      chk("wait_line3_h20", 32'(found), 1);
      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
      chk("midrst_line",  32'(a_line),  0);
      chk("midrst_csync", 32'(a_csync), 1);
      cyc();
      chk("midrst_dot", 32'(a_dot), 1);
      chk("midrst_hsync", 32'(a_csync), 0);

      // step 5: freeze 37 cycles on the last mclk of a line
      found = 0;
      for (int i = 0; i < 200 && !found; i++) begin
         if (ma.h == PA.ht - 1 && ma.line != PA.sl) found = 1;
         else cyc();
      end
      chk("wait_h_last", 32'(found), 1);
      line_before = ma.line;
      en = 1'b0;
      repeat (37) cyc();
      en = 1'b1;
      cyc();
      chk("freeze_dot_phase", 32'(a_dot), 0);
      chk("freeze_line_held", 32'(a_line), line_before);
      cyc();
      chk("freeze_wrap_line", 32'(a_line), (line_before + 1) % PA.vt);
      chk("freeze_wrap_dot", 32'(a_dot), 1);

      // step 6: randomized enable, interlace and occasional reset
      for (int i = 0; i < 20000; i++) begin
         en = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 2999) == 0) intl = ~intl;
         rst_n = ($urandom_range(0, 3999) != 0);
         cyc();
      end
      rst_n = 1'b1;
      en = 1'b1;
      repeat (10) cyc();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
